branch_resolver: RTL and testbench
==================================

# branch_resolver

Execute-stage partner to the fetch-side branch predictor. The predictor always assumes BL and conditional branches are taken, and hands the fall-through PC (LBPC) and pre-branch PSW (LBPSW) down the pipe. This block evaluates each conditional branch against the live PSW flags when it reaches execute. On a wrong prediction it issues a one-cycle PC redirect and PSW restore, and squashes the two wrong-path stages. It also keeps saturating branch and mispredict counters for the debug LEDs.

## Interface
- No parameters; all widths fixed.
- clk  in  1  system clock; all state updates on posedge clk.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  a real, non-bubble instruction occupies execute this cycle.
- ex_stall  in  1  execute held by hazard stall; when high, the current cycle is treated as a bubble.
- ex_is_bl  in  1  instruction in execute is BL (opcode 3'b000), always taken.
- ex_is_cond  in  1  instruction in execute is a conditional branch (opcode 3'b001).
- ex_cond  in  3  condition field: 000 EQ, 001 NE, 010 C, 011 NC, 100 N, 101 GE, 110 LT, 111 AL.
- psw_flags  in  4  live flags {V,N,Z,C} (bit3..bit0) as seen by execute.
- lbpc  in  16  fall-through PC delivered with the branch.
- lbpsw  in  16  PSW snapshot delivered with the branch.
- cnt_clr  in  1  clear both counters.
- led_sel  in  2  debug select.
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  out  16  corrected PC.
- psw_restore_en  out  1  one-cycle pulse, coincident with redirect_valid.
- psw_restore  out  16  PSW value to write back.
- flush_fetch  out  1  squash the instruction in fetch.
- flush_decode  out  1  squash the instruction in decode.
- busy  out  1  resolver in a flush state.
- branch_cnt  out  16  resolved conditional branches, saturating.
- mispredict_cnt  out  16  mispredictions, saturating.
- led  out  8  debug view.

## Operation
- resolve = ex_valid & ~ex_stall & ex_is_cond & (state == IDLE).
- Condition truth:
  - EQ=Z, NE=~Z.
  - C=C, NC=~C.
  - N=N.
  - GE=~(N^V), LT=N^V.
  - AL=1.
- mispredict = resolve & ~truth. The predictor always predicts taken, so a taken branch is correct and needs no action.
- BL is never mispredicted and is never counted. ex_is_bl is accepted for completeness only. If both ex_is_bl and ex_is_cond are set, ex_is_bl wins and no resolve occurs.
- State machine:
  - IDLE → FLUSH1 when mispredict. redirect_pc<=lbpc, psw_restore<=lbpsw, both registered.
  - FLUSH1 → FLUSH2 unconditionally.
  - FLUSH2 → IDLE unconditionally.
- In FLUSH1 and FLUSH2, execute contents are wrong-path. ex_valid is ignored: no resolve and no counting.
- Outputs by state:
  - redirect_valid = psw_restore_en = (state == FLUSH1).
  - flush_fetch = flush_decode = busy = (state != IDLE).
- Counters:
  - branch_cnt += 1 on resolve.
  - mispredict_cnt += 1 on mispredict.
  - Both hold at 16'hFFFF once reached; no wrap.
  - cnt_clr zeroes both and takes priority over a same-cycle increment.
- led output:
  - 00 → mispredict_cnt[7:0].
  - 01 → branch_cnt[7:0].
  - 10 → {5'b0, state[1:0], redirect_valid}, with state encoding IDLE=00, FLUSH1=01, FLUSH2=10.
  - 11 → 8'h00.

## Timing
- Reset values: state IDLE, every output 0. This includes redirect_pc, psw_restore, both counters and led; led reads 0 for every led_sel.
- Mispredict seen in cycle N (sampled at edge N+1):
  - redirect_valid and psw_restore_en high during cycle N+1 only.
  - flush_* and busy high during cycles N+1 and N+2.
  - A new resolve is possible at the earliest in cycle N+3.
- redirect_pc and psw_restore hold their last captured value until the next mispredict.
- Counters update at the edge that ends the resolving cycle; visible the next cycle.
- rst in any cycle, including FLUSH1 or FLUSH2, returns to IDLE at that edge. It drops any pending redirect and clears the counters. rst has priority over every other input.
- A stalled cycle (ex_stall=1) never resolves. The branch resolves in the first unstalled cycle it is presented, exactly once.
- No combinational path from inputs to redirect/flush outputs; only led depends combinationally on led_sel.

## Test plan
- Reset: assert rst with counters at nonzero values → next cycle all outputs 0, state IDLE, led 0 for every led_sel.
- Correct prediction: ex_cond=000 (EQ), Z=1, ex_valid=1 → no redirect, no flush; branch_cnt=1, mispredict_cnt=0.
- Mispredict: ex_cond=101 (GE), N=1, V=0, lbpc=16'h0124, lbpsw=16'h00A3 → next cycle redirect_valid=1, redirect_pc=16'h0124, psw_restore=16'h00A3. Flush high 2 cycles; a branch presented in FLUSH2 is not counted; mispredict_cnt=1.
- Stall and reset: ex_stall=1 for 3 cycles with a NE branch and Z=1 → no action until the stall drops, then exactly one redirect. Separately, rst pulsed in FLUSH1 → IDLE next cycle, flush_* low.
- Saturation and clear: preload counters to 16'hFFFE, apply 3 mispredicts → both read 16'hFFFF. Then cnt_clr together with a resolve → both read 0.
- Condition sweep: all 8 ex_cond codes against all 16 psw_flags values → redirect occurs exactly when the truth function is 0. AL never redirects.

Source files
------------

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: checks always-taken predictions against live PSW flags,
// issues a one-cycle redirect/PSW restore on a miss and keeps saturating debug counters.
module branch_resolver (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic        ex_is_bl,
  input  logic        ex_is_cond,
  input  logic [2:0]  ex_cond,
  input  logic [3:0]  psw_flags,
  input  logic [15:0] lbpc,
  input  logic [15:0] lbpsw,
  input  logic        cnt_clr,
  input  logic [1:0]  led_sel,
  output logic        redirect_valid,
  output logic [15:0] redirect_pc,
  output logic        psw_restore_en,
  output logic [15:0] psw_restore,
  output logic        flush_fetch,
  output logic        flush_decode,
  output logic        busy,
  output logic [15:0] branch_cnt,
  output logic [15:0] mispredict_cnt,
  output logic [7:0]  led
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FLUSH1 = 2'b01,
    FLUSH2 = 2'b10
  } state_t;

  state_t      state, state_next;
  logic        cond_true;
  logic        resolve;
  logic        mispredict;
  logic        flag_v, flag_n, flag_z, flag_c;
  logic [15:0] branch_cnt_q, mispredict_cnt_q;
  logic [15:0] redirect_pc_q, psw_restore_q;

  assign {flag_v, flag_n, flag_z, flag_c} = psw_flags;

  always_comb begin
    cond_true = 1'b1;
    case (ex_cond)
      3'b000:  cond_true = flag_z;
      3'b001:  cond_true = ~flag_z;
      3'b010:  cond_true = flag_c;
      3'b011:  cond_true = ~flag_c;
      3'b100:  cond_true = flag_n;
      3'b101:  cond_true = ~(flag_n ^ flag_v);
      3'b110:  cond_true = flag_n ^ flag_v;
      default: cond_true = 1'b1;
    endcase
  end

  // BL takes precedence over a conditional decode, and wrong-path slots never resolve
  assign resolve    = ex_valid & ~ex_stall & ex_is_cond & ~ex_is_bl & (state == IDLE);
  assign mispredict = resolve & ~cond_true;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mispredict) state_next = FLUSH1;
      FLUSH1:  state_next = FLUSH2;
      FLUSH2:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pc_q <= 16'h0000;
      psw_restore_q <= 16'h0000;
    end else if (mispredict) begin
      redirect_pc_q <= lbpc;
      psw_restore_q <= lbpsw;
    end
  end

  // Counters stick at all-ones; a clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      branch_cnt_q     <= 16'h0000;
      mispredict_cnt_q <= 16'h0000;
    end else begin
      if (resolve && branch_cnt_q != 16'hFFFF)
        branch_cnt_q <= branch_cnt_q + 16'd1;
      if (mispredict && mispredict_cnt_q != 16'hFFFF)
        mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
    end
  end

  assign redirect_valid = (state == FLUSH1);
  assign psw_restore_en = (state == FLUSH1);
  assign flush_fetch    = (state != IDLE);
  assign flush_decode   = (state != IDLE);
  assign busy           = (state != IDLE);
  assign redirect_pc    = redirect_pc_q;
  assign psw_restore    = psw_restore_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

  always_comb begin
    led = 8'h00;
    case (led_sel)
      2'b00:   led = mispredict_cnt_q[7:0];
      2'b01:   led = branch_cnt_q[7:0];
      2'b10:   led = {5'b00000, state, redirect_valid};
      default: led = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed and randomized bench for branch_resolver, checked against a cycle-level
// reference model built from the condition rules and a flush countdown.
`timescale 1ns/1ps
module tb_branch_resolver;

  logic        clk;
  logic        rst;
  logic        ex_valid, ex_stall, ex_is_bl, ex_is_cond;
  logic [2:0]  ex_cond;
  logic [3:0]  psw_flags;
  logic [15:0] lbpc, lbpsw;
  logic        cnt_clr;
  logic [1:0]  led_sel;
  logic        redirect_valid, psw_restore_en;
  logic [15:0] redirect_pc, psw_restore;
  logic        flush_fetch, flush_decode, busy;
  logic [15:0] branch_cnt, mispredict_cnt;
  logic [7:0]  led;

  int          errors = 0;
  int          checks = 0;

  int          m_flush;
  logic [15:0] m_bcnt, m_mcnt, m_pc, m_psw;

  branch_resolver dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_is_bl(ex_is_bl), .ex_is_cond(ex_is_cond),
    .ex_cond(ex_cond), .psw_flags(psw_flags), .lbpc(lbpc), .lbpsw(lbpsw),
    .cnt_clr(cnt_clr), .led_sel(led_sel),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .psw_restore_en(psw_restore_en), .psw_restore(psw_restore),
    .flush_fetch(flush_fetch), .flush_decode(flush_decode), .busy(busy),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt), .led(led)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic bit taken(input logic [2:0] cond, input logic [3:0] flags);
    bit v, n, z, c;
    v = flags[3]; n = flags[2]; z = flags[1]; c = flags[0];
    case (cond)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return c;
      3'd3: return !c;
      3'd4: return n;
      3'd5: return n == v;
      3'd6: return n != v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  function automatic logic [7:0] exp_led(input logic [1:0] sel);
    logic [1:0] code;
    code = (m_flush == 2) ? 2'b01 : (m_flush == 1) ? 2'b10 : 2'b00;
    case (sel)
      2'd0: return m_mcnt[7:0];
      2'd1: return m_bcnt[7:0];
      2'd2: return {5'b00000, code, m_flush == 2};
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then advance the model across the same edge
  task automatic applyStimulus(input logic r, input logic v, input logic st, input logic bl,
                               input logic cd, input logic [2:0] cond, input logic [3:0] flags,
                               input logic [15:0] pc, input logic [15:0] psw, input logic clr);
    bit res, mis;
    @(negedge clk);
    rst = r; ex_valid = v; ex_stall = st; ex_is_bl = bl; ex_is_cond = cd;
    ex_cond = cond; psw_flags = flags; lbpc = pc; lbpsw = psw; cnt_clr = clr;
    led_sel = 2'($urandom_range(0, 3));
    @(posedge clk);
    if (r) begin
      m_flush = 0; m_bcnt = 0; m_mcnt = 0; m_pc = 0; m_psw = 0;
    end else begin
      res = v && !st && cd && !bl && (m_flush == 0);
      mis = res && !taken(cond, flags);
      if (clr) begin
        m_bcnt = 0; m_mcnt = 0;
      end else begin
        if (res) m_bcnt = sat_inc(m_bcnt);
        if (mis) m_mcnt = sat_inc(m_mcnt);
      end
      if (m_flush > 0) m_flush = m_flush - 1;
      else if (mis) begin
        m_flush = 2; m_pc = pc; m_psw = psw;
      end
    end
    #1;
  endtask

  task automatic idleStep();
    applyStimulus(0, 0, 0, 0, 0, 3'd0, 4'd0, 16'h0000, 16'h0000, 0);
  endtask

  task automatic checkOutput(input string tag);
    logic [15:0] one_if_flush;
    one_if_flush = (m_flush != 0) ? 16'd1 : 16'd0;
    chk({tag, " redirect_valid"}, {15'b0, redirect_valid}, (m_flush == 2) ? 16'd1 : 16'd0);
    chk({tag, " psw_restore_en"}, {15'b0, psw_restore_en}, (m_flush == 2) ? 16'd1 : 16'd0);
    chk({tag, " redirect_pc"}, redirect_pc, m_pc);
    chk({tag, " psw_restore"}, psw_restore, m_psw);
    chk({tag, " flush_fetch"}, {15'b0, flush_fetch}, one_if_flush);
    chk({tag, " flush_decode"}, {15'b0, flush_decode}, one_if_flush);
    chk({tag, " busy"}, {15'b0, busy}, one_if_flush);
    chk({tag, " branch_cnt"}, branch_cnt, m_bcnt);
    chk({tag, " mispredict_cnt"}, mispredict_cnt, m_mcnt);
    chk({tag, " led"}, {8'b0, led}, {8'b0, exp_led(led_sel)});
  endtask

  task automatic checkLeds(input string tag);
    for (int s = 0; s < 4; s++) begin
      led_sel = 2'(s);
      #1;
      chk($sformatf("%s led_sel=%0d", tag, s), {8'b0, led}, {8'b0, exp_led(2'(s))});
    end
  endtask

  task automatic drainFlush(input string tag);
    while (m_flush != 0) begin
      idleStep();
      checkOutput(tag);
    end
  endtask

  initial begin
    m_flush = 0; m_bcnt = 0; m_mcnt = 0; m_pc = 0; m_psw = 0;
    rst = 1; ex_valid = 0; ex_stall = 0; ex_is_bl = 0; ex_is_cond = 0;
    ex_cond = 0; psw_flags = 0; lbpc = 0; lbpsw = 0; cnt_clr = 0; led_sel = 0;

    $display("[TB] reset");
    applyStimulus(1, 0, 0, 0, 0, 3'd0, 4'd0, 16'h0, 16'h0, 0);
    applyStimulus(1, 1, 0, 0, 1, 3'd1, 4'b0010, 16'h1111, 16'h2222, 0);
    checkOutput("reset");
    checkLeds("reset");

    $display("[TB] correct prediction EQ");
    applyStimulus(0, 1, 0, 0, 1, 3'd0, 4'b0010, 16'h0042, 16'h0007, 0);
    checkOutput("eq_taken");
    chk("eq_taken branch_cnt is 1", branch_cnt, 16'd1);

    $display("[TB] mispredict GE");
    applyStimulus(0, 1, 0, 0, 1, 3'd5, 4'b0100, 16'h0124, 16'h00A3, 0);
    checkOutput("ge_miss");
    chk("ge_miss redirect_pc literal", redirect_pc, 16'h0124);
    chk("ge_miss psw_restore literal", psw_restore, 16'h00A3);
    applyStimulus(0, 1, 0, 0, 1, 3'd1, 4'b0010, 16'h0200, 16'h0300, 0);
    checkOutput("ge_flush1");
    applyStimulus(0, 1, 0, 0, 1, 3'd1, 4'b0010, 16'h0400, 16'h0500, 0);
    checkOutput("ge_flush2_branch_ignored");
    chk("ge mispredict_cnt is 1", mispredict_cnt, 16'd1);
    idleStep();
    checkOutput("ge_back_idle");

    $display("[TB] stall then resolve once");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 0, 1, 3'd1, 4'b0010, 16'h0ABC, 16'h00DE, 0);
      checkOutput("stall_hold");
    end
    applyStimulus(0, 1, 0, 0, 1, 3'd1, 4'b0010, 16'h0ABC, 16'h00DE, 0);
    checkOutput("stall_release");
    drainFlush("stall_flush");

    $display("[TB] reset during FLUSH1");
    applyStimulus(0, 1, 0, 0, 1, 3'd0, 4'b0000, 16'h7777, 16'h0055, 0);
    checkOutput("pre_rst_miss");
    applyStimulus(1, 0, 0, 0, 0, 3'd0, 4'd0, 16'h0, 16'h0, 0);
    checkOutput("rst_in_flush1");

    $display("[TB] saturation and clear");
    force dut.branch_cnt_q = 16'hFFFE;
    force dut.mispredict_cnt_q = 16'hFFFE;
    #1;
    release dut.branch_cnt_q;
    release dut.mispredict_cnt_q;
    m_bcnt = 16'hFFFE; m_mcnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 1, 3'd2, 4'b0000, 16'($urandom), 16'($urandom), 0);
      checkOutput("sat_miss");
      drainFlush("sat_flush");
    end
    chk("sat branch_cnt", branch_cnt, 16'hFFFF);
    chk("sat mispredict_cnt", mispredict_cnt, 16'hFFFF);
    applyStimulus(0, 1, 0, 0, 1, 3'd7, 4'b0000, 16'h0, 16'h0, 1);
    checkOutput("clr_with_resolve");
    chk("clr branch_cnt", branch_cnt, 16'h0000);

    $display("[TB] condition sweep");
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 16; f++) begin
        applyStimulus(0, 1, 0, 0, 1, 3'(c), 4'(f), 16'($urandom), 16'($urandom), 0);
        checkOutput($sformatf("sweep c=%0d f=%0d", c, f));
        drainFlush("sweep_flush");
      end
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 1) == 1, 3'($urandom), 4'($urandom),
                    16'($urandom), 16'($urandom), $urandom_range(0, 30) == 0);
      checkOutput("random");
    end

    $display("[TB] reset with nonzero counters");
    drainFlush("pre_final_rst");
    applyStimulus(0, 1, 0, 0, 1, 3'd3, 4'b0001, 16'h5A5A, 16'hA5A5, 0);
    applyStimulus(1, 0, 0, 0, 0, 3'd0, 4'd0, 16'h0, 16'h0, 0);
    checkOutput("final_reset");
    checkLeds("final_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
